// File: rtl/npu_pkg.sv
// Shared definitions for the NPU element-wise ALU: op codes, frame size,
// saturation bounds and the FSM state type.
package npu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_MAX   = 3'b011;
  localparam logic [2:0] OP_MIN   = 3'b100;
  localparam logic [2:0] OP_RELU  = 3'b101;
  localparam logic [2:0] OP_PASSA = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  localparam int N_ELEM_DFLT = 1024;

  localparam logic signed [7:0] SAT_MAX = 8'sd127;
  localparam logic signed [7:0] SAT_MIN = -8'sd128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic signed [16:0] sext17(input logic signed [7:0] x);
    return {{9{x[7]}}, x};
  endfunction

endpackage

// File: rtl/npu_sat8.sv
// Combinational clamp of a 17-bit signed intermediate to the signed 8-bit
// result range; clamp flags that the value was out of range.
module npu_sat8
  import npu_pkg::*;
(
  input  logic signed [16:0] din,
  output logic signed [7:0]  dout,
  output logic               clamp
);

  localparam logic signed [16:0] HI = {{9{SAT_MAX[7]}}, SAT_MAX};
  localparam logic signed [16:0] LO = {{9{SAT_MIN[7]}}, SAT_MIN};

  always_comb begin
    dout  = din[7:0];
    clamp = 1'b0;
    if (din > HI) begin
      dout  = SAT_MAX;
      clamp = 1'b1;
    end else if (din < LO) begin
      dout  = SAT_MIN;
      clamp = 1'b1;
    end
  end

endmodule

// File: rtl/npu_alu.sv
// Element-wise 8-bit signed ALU over one N_ELEM frame per start.
// Define NPU_ALU_MUL_EN to build the 8x8 multiplier for OP_MUL; otherwise OP_MUL is PASS A.
module npu_alu
  import npu_pkg::*;
#(
  parameter int IN_LAT = 2,
  parameter int N_ELEM = N_ELEM_DFLT
) (
  input  logic              CLK,
  input  logic              rst_x,
  input  logic              CLR,
  input  logic [2:0]        OP,
  input  logic [2:0]        SHIFT,
  input  logic              NPU_EN,
  input  logic signed [7:0] A_RDATA,
  input  logic signed [7:0] B_RDATA,
  output logic              LM_EN,
  output logic signed [7:0] C_WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVF,
  output state_t            dbg_state
);

  // Handshake: LM_EN=1 marks C_WDATA as a result the controller must take
  // that cycle; there is no ready/backpressure, so results never stall.

  localparam int CNT_W = $clog2(N_ELEM) + 1;

  state_t              state;
  logic [IN_LAT-1:0]   vld_sr;
  logic                vld_in;
  logic                sr_in;
  logic                start;
  logic                accept;
  logic [CNT_W-1:0]    count;
  logic [2:0]          op_q;
  logic                s1_vld;
  logic signed [16:0]  s1_raw;
  logic signed [16:0]  raw;
  logic signed [16:0]  a_x;
  logic signed [16:0]  b_x;
  logic signed [7:0]   sat_out;
  logic                sat_clamp;

  assign a_x    = sext17(A_RDATA);
  assign b_x    = sext17(B_RDATA);
  assign vld_in = vld_sr[IN_LAT-1];
  assign start  = (state == ST_IDLE) && NPU_EN && !DONE;
  // Enables outside a live frame (DONE cycle, DRAIN) are dropped before they
  // can turn into late operand-valid pulses.
  assign sr_in  = NPU_EN && ((state == ST_IDLE && !DONE) || state == ST_RUN);
  assign accept = (state == ST_RUN) && vld_in && (count < CNT_W'(N_ELEM));
  assign dbg_state = state;

`ifdef NPU_ALU_MUL_EN
  logic [2:0]         shift_q;
  logic signed [15:0] prod;
  logic signed [16:0] prod_x;

  assign prod   = A_RDATA * B_RDATA;
  assign prod_x = {prod[15], prod};

  always_ff @(posedge CLK or negedge rst_x) begin
    if (!rst_x) begin
      shift_q <= '0;
    end else if (CLR) begin
      shift_q <= '0;
    end else if (start) begin
      shift_q <= SHIFT;
    end
  end
`else
  logic unused_shift;
  assign unused_shift = ^SHIFT;
`endif

  always_comb begin
    raw = a_x;
    case (op_q)
      OP_ADD:   raw = a_x + b_x;
      OP_SUB:   raw = a_x - b_x;
`ifdef NPU_ALU_MUL_EN
      OP_MUL:   raw = prod_x >>> shift_q;
`else
      OP_MUL:   raw = a_x;
`endif
      OP_MAX:   raw = (a_x > b_x) ? a_x : b_x;
      OP_MIN:   raw = (a_x < b_x) ? a_x : b_x;
      OP_RELU:  raw = a_x[16] ? '0 : a_x;
      OP_PASSA: raw = a_x;
      OP_PASSB: raw = b_x;
      default:  raw = a_x;
    endcase
  end

  npu_sat8 u_sat (
    .din   (s1_raw),
    .dout  (sat_out),
    .clamp (sat_clamp)
  );

  always_ff @(posedge CLK or negedge rst_x) begin
    if (!rst_x) begin
      state   <= ST_IDLE;
      vld_sr  <= '0;
      count   <= '0;
      op_q    <= OP_ADD;
      s1_vld  <= 1'b0;
      s1_raw  <= '0;
      LM_EN   <= 1'b0;
      C_WDATA <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      OVF     <= 1'b0;
    end else if (CLR) begin
      state   <= ST_IDLE;
      vld_sr  <= '0;
      count   <= '0;
      op_q    <= OP_ADD;
      s1_vld  <= 1'b0;
      s1_raw  <= '0;
      LM_EN   <= 1'b0;
      C_WDATA <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      vld_sr[0] <= sr_in;
      for (int i = 1; i < IN_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end

      s1_vld <= accept;
      if (accept) begin
        s1_raw <= raw;
      end

      LM_EN <= s1_vld;
      if (s1_vld) begin
        C_WDATA <= sat_out;
        if (sat_clamp) begin
          OVF <= 1'b1;
        end
      end

      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= OP;
            count <= '0;
            BUSY  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            count <= count + 1'b1;
          end
          if ((accept && count == CNT_W'(N_ELEM - 1)) || (!NPU_EN && vld_sr == '0)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Stage 1 empty means the final result is on LM_EN this cycle.
          if (!s1_vld) begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_alu.sv
// Directed scoreboard bench for npu_alu: the driver queues expected results,
// a negedge monitor pops and compares them whenever LM_EN is high.
module tb_npu_alu;
  import npu_pkg::*;

  localparam int IN_LAT = 2;
  localparam int NE     = 1024;

  logic        CLK = 1'b0;
  logic        rst_x = 1'b0;
  logic        CLR = 1'b0;
  logic [2:0]  OP = 3'b000;
  logic [2:0]  SHIFT = 3'b000;
  logic        NPU_EN = 1'b0;
  logic [7:0]  A_RDATA = 8'h00;
  logic [7:0]  B_RDATA = 8'h00;
  logic        LM_EN;
  logic [7:0]  C_WDATA;
  logic        BUSY;
  logic        DONE;
  logic        OVF;
  state_t      dbg_state;

  npu_alu #(.IN_LAT(IN_LAT), .N_ELEM(NE)) dut (
    .CLK       (CLK),
    .rst_x     (rst_x),
    .CLR       (CLR),
    .OP        (OP),
    .SHIFT     (SHIFT),
    .NPU_EN    (NPU_EN),
    .A_RDATA   (A_RDATA),
    .B_RDATA   (B_RDATA),
    .LM_EN     (LM_EN),
    .C_WDATA   (C_WDATA),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .OVF       (OVF),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  lm_total = 0;
  int  done_total = 0;
  logic prev_lm = 1'b0;
  bit  abort = 1'b0;
  int  start_cyc = 0;
  int  lm_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (rst_x) begin
        if (LM_EN) begin
          lm_total++;
          if (exp_q.size() == 0) begin
            check("extra_result", 1, 0);
          end else begin
            check("c_wdata", int'(C_WDATA), int'(exp_q.pop_front()));
          end
        end
        if (DONE) begin
          done_total++;
          check("done_after_lm", int'(prev_lm), 1);
        end
        prev_lm = LM_EN;
      end
    end
  end

  // driver tasks
  task automatic drive_frame(input logic [2:0] op, input logic [2:0] sh, input int n,
                             input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    @(posedge CLK); #1;
    OP = op; SHIFT = sh; A_RDATA = a; B_RDATA = b;
    start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (abort) break;
      NPU_EN = 1'b1;
      exp_q.push_back(e);
      @(posedge CLK); #1;
    end
    NPU_EN = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    bit got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge CLK);
      if (DONE) got = 1'b1;
    end
    check("done_seen", int'(got), 1);
    check("busy_at_done", int'(BUSY), 0);
  endtask

  task automatic run_frame(input logic [2:0] op, input logic [2:0] sh, input int n,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    int base;
    base = lm_total;
    fork
      drive_frame(op, sh, n, a, b, e);
      begin
        for (int i = 0; i < 20 && !LM_EN; i++) @(negedge CLK);
        lm_cyc = cyc;
      end
    join
    check("first_lm_latency", lm_cyc - start_cyc, IN_LAT + 2);
    wait_done(60);
    check("result_count", lm_total - base, n);
    check("queue_drained", exp_q.size(), 0);
    check("state_idle", int'(dbg_state), int'(ST_IDLE));
  endtask

  task automatic pulse_clr();
    @(posedge CLK); #1; CLR = 1'b1;
    @(posedge CLK); #1; CLR = 1'b0;
  endtask

  logic [7:0] mul_e1, mul_e2;
  int         mul_ovf1;

  initial begin
    int base, base_done, lm_at_clr;
`ifdef NPU_ALU_MUL_EN
    mul_e1 = 8'h80; mul_ovf1 = 1; mul_e2 = 8'h0F;
`else
    mul_e1 = 8'hC0; mul_ovf1 = 0; mul_e2 = 8'h0C;
`endif
    // reset
    repeat (3) @(posedge CLK);
    #1 rst_x = 1'b1;
    @(negedge CLK);
    check("rst_lm_en", int'(LM_EN), 0);
    check("rst_c_wdata", int'(C_WDATA), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_ovf", int'(OVF), 0);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));

    // full ADD frame saturating high
    run_frame(OP_ADD, 3'd0, NE, 8'd100, 8'd50, 8'h7F);
    check("add_ovf", int'(OVF), 1);
    pulse_clr();
    @(negedge CLK);
    check("clr_ovf", int'(OVF), 0);

    // SUB without clamp: -100 - 20 = -120
    run_frame(OP_SUB, 3'd0, 16, 8'h9C, 8'h14, 8'h88);
    check("sub_ovf", int'(OVF), 0);

    // MUL: -64*64 >>> 3 = -512 clamps; 12*10 >>> 3 = 15
    run_frame(OP_MUL, 3'd3, 8, 8'hC0, 8'h40, mul_e1);
    check("mul1_ovf", int'(OVF), mul_ovf1);
    pulse_clr();
    run_frame(OP_MUL, 3'd3, 8, 8'h0C, 8'h0A, mul_e2);
    check("mul2_ovf", int'(OVF), 0);

    // MAX / MIN / RELU on A=-5, B=3
    run_frame(OP_MAX, 3'd0, 4, 8'hFB, 8'h03, 8'h03);
    run_frame(OP_MIN, 3'd0, 4, 8'hFB, 8'h03, 8'hFB);
    run_frame(OP_RELU, 3'd0, 4, 8'hFB, 8'h03, 8'h00);
    run_frame(OP_PASSB, 3'd0, 4, 8'hFB, 8'h03, 8'h03);
    check("cmp_ovf", int'(OVF), 0);

    // short frame of 10 elements
    run_frame(OP_ADD, 3'd0, 10, 8'd1, 8'd2, 8'h03);

    // CLR after 500 results of a saturating frame
    base = lm_total;
    lm_at_clr = 0;
    abort = 1'b0;
    fork
      drive_frame(OP_ADD, 3'd0, NE, 8'd100, 8'd50, 8'h7F);
      begin
        for (int i = 0; i < 2000 && (lm_total - base) < 500; i++) @(negedge CLK);
        check("reach_500", int'((lm_total - base) >= 500), 1);
        check("ovf_before_clr", int'(OVF), 1);
        abort = 1'b1;
        @(posedge CLK); #1; CLR = 1'b1;
        @(posedge CLK); #1; CLR = 1'b0;
        exp_q.delete();
        lm_at_clr = lm_total;
      end
    join
    @(negedge CLK);
    check("clr_lm_en", int'(LM_EN), 0);
    check("clr_busy", int'(BUSY), 0);
    check("clr_ovf2", int'(OVF), 0);
    check("clr_state", int'(dbg_state), int'(ST_IDLE));
    base_done = done_total;
    repeat (20) @(negedge CLK);
    check("clr_no_done", done_total - base_done, 0);
    check("clr_no_results", lm_total - lm_at_clr, 0);

    // restart a full frame after CLR
    abort = 1'b0;
    run_frame(OP_ADD, 3'd0, NE, 8'd3, 8'd4, 8'h07);
    check("restart_ovf", int'(OVF), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
